// File: rtl/fp_pkg.sv
// Shared types and width helpers for the FP normalize/round back end.
package fp_pkg;
  typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RDN = 2'd2, RUP = 2'd3} rm_e;

  typedef struct packed {
    logic ovf;
    logic uf;
    logic inexact;
    logic zero;
  } fp_flags_t;

  localparam int FP_M   = 23;
  localparam int FP_MW  = 2*FP_M + 3;
  localparam int FP_LZW = $clog2(FP_MW);

  function automatic int mant_w(input int m);
    return 2*m + 3;
  endfunction

  function automatic int lz_w(input int m);
    return $clog2(2*m + 3);
  endfunction

  function automatic int exp_ones(input int e);
    return (1 << e) - 1;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter from the MSB; count is don't-care when all_zero is set.
module fp_lzc #(
  parameter int WIDTH = 49,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [CW-1:0]    count,
  output logic             all_zero
);
  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1'b1;
        else      count = count + CW'(1);
      end
    end
  end

  assign all_zero = ~|d;
endmodule

// File: rtl/fp_normalize_round_pipe.sv
// Three-stage multi-lane normalize/round/pack back end with valid/ready flow.
// Define FP_NORM_SUBNORMAL_EN to emit subnormals instead of flushing to zero.
module fp_normalize_round_pipe
  import fp_pkg::*;
#(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int LANES = 1,
  parameter int TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_sign,
  input  logic [LANES*(2*M+3)-1:0] in_m,
  input  logic [LANES*(E+2)-1:0]   in_e,
  input  logic [1:0]               in_rm,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_sign,
  output logic [LANES*E-1:0]       out_e,
  output logic [LANES*M-1:0]       out_m,
  output logic [LANES*4-1:0]       out_flags,
  output logic [TAG_W-1:0]         out_tag
);
  localparam int MW = mant_w(M);
  localparam int LW = lz_w(M);
  localparam int EW = E + 3;
  localparam logic signed [EW-1:0] EMAX  = EW'(exp_ones(E));
  localparam logic signed [EW-1:0] EZERO = '0;

  logic [LANES-1:0][MW-1:0]  m_in;
  logic [LANES-1:0][E+1:0]   e_in;
  assign m_in = in_m;
  assign e_in = in_e;

  // Each stage loads when empty or when its successor loads.
  logic [3:1] vld_pipe;
  logic ld1, ld2, ld3;
  assign ld3       = !vld_pipe[3] || out_ready;
  assign ld2       = !vld_pipe[2] || ld3;
  assign ld1       = !vld_pipe[1] || ld2;
  assign in_ready  = ld1;
  assign out_valid = vld_pipe[3];

  logic [LANES-1:0]          s1_sign, s1_zero, az_c;
  logic [LANES-1:0][MW-1:0]  s1_m;
  logic [LANES-1:0][E+1:0]   s1_e;
  logic [LANES-1:0][LW-1:0]  s1_lz, lz_c;
  rm_e                       s1_rm, s2_rm;
  logic [TAG_W-1:0]          s1_tag, s2_tag;

  logic [LANES-1:0]          s2_sign, s2_zero, s2_guard, s2_sticky, guard_c, sticky_c;
  logic [LANES-1:0][M:0]     s2_kept, kept_c;
  logic [LANES-1:0][EW-1:0]  s2_e, ep_c;

  logic [LANES-1:0][E-1:0]   oe_c, o_e;
  logic [LANES-1:0][M-1:0]   om_c, o_m;
  fp_flags_t [LANES-1:0]     fl_c, o_fl;

  assign out_e     = o_e;
  assign out_m     = o_m;
  assign out_flags = o_fl;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_sign <= '0; s1_zero <= '0; s1_m <= '0; s1_e <= '0; s1_lz <= '0;
      s1_rm <= RNE; s1_tag <= '0;
      s2_sign <= '0; s2_zero <= '0; s2_guard <= '0; s2_sticky <= '0;
      s2_kept <= '0; s2_e <= '0; s2_rm <= RNE; s2_tag <= '0;
      out_sign <= '0; o_e <= '0; o_m <= '0; o_fl <= '0; out_tag <= '0;
    end else begin
      if (ld1) vld_pipe[1] <= in_valid;
      if (ld2) vld_pipe[2] <= vld_pipe[1];
      if (ld3) vld_pipe[3] <= vld_pipe[2];
      if (ld1 && in_valid) begin
        s1_sign <= in_sign; s1_m <= m_in; s1_e <= e_in; s1_lz <= lz_c;
        s1_zero <= az_c; s1_rm <= rm_e'(in_rm); s1_tag <= in_tag;
      end
      if (ld2 && vld_pipe[1]) begin
        s2_sign <= s1_sign; s2_zero <= s1_zero; s2_guard <= guard_c;
        s2_sticky <= sticky_c; s2_kept <= kept_c; s2_e <= ep_c;
        s2_rm <= s1_rm; s2_tag <= s1_tag;
      end
      if (ld3 && vld_pipe[2]) begin
        out_sign <= s2_sign; o_e <= oe_c; o_m <= om_c; o_fl <= fl_c; out_tag <= s2_tag;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MW-1:0]          nrm;
    logic [M:0]             kept;
    logic                   grd, stk, inc, to_inf, lane_unused;
    logic [M+1:0]           sum;
    logic signed [EW-1:0]   ep, er;
    logic [E-1:0]           oe;
    logic [M-1:0]           om;
    fp_flags_t              fl;
`ifdef FP_NORM_SUBNORMAL_EN
    logic [M+2:0]           v, vs;
    logic [EW-1:0]          sh;
`endif

    fp_lzc #(.WIDTH(MW), .CW(LW)) u_lzc (
      .d(m_in[i]), .count(lz_c[i]), .all_zero(az_c[i])
    );

    // Hidden bit lands on the carry position; exponent rebiased to match.
    assign nrm         = s1_m[i] << s1_lz[i];
    assign kept_c[i]   = nrm[MW-1 -: M+1];
    assign guard_c[i]  = nrm[M+1];
    assign sticky_c[i] = |nrm[M:0];
    assign ep_c[i]     = {s1_e[i][E+1], s1_e[i]} + EW'(1) - {{(EW-LW){1'b0}}, s1_lz[i]};

    always_comb begin
      ep   = $signed(s2_e[i]);
      kept = s2_kept[i];
      grd  = s2_guard[i];
      stk  = s2_sticky[i];
`ifdef FP_NORM_SUBNORMAL_EN
      v  = '0;
      vs = '0;
      sh = '0;
      if (ep <= EZERO) begin
        // Denormalize: the sticky slot only absorbs, it never moves up.
        sh   = EW'(1) - s2_e[i];
        v    = {kept, grd, stk};
        vs   = v >> sh;
        kept = vs[M+2:2];
        grd  = vs[1];
        stk  = vs[0] | (|(v & ~({(M+3){1'b1}} << sh)));
      end
`endif
      case (s2_rm)
        RNE:     inc = grd & (stk | kept[0]);
        RTZ:     inc = 1'b0;
        RDN:     inc = s2_sign[i] & (grd | stk);
        default: inc = ~s2_sign[i] & (grd | stk);
      endcase
      sum    = {1'b0, kept} + {{(M+1){1'b0}}, inc};
      er     = ep + $signed({{(EW-1){1'b0}}, sum[M+1]});
      to_inf = (s2_rm == RNE) || (s2_rm == RDN && s2_sign[i]) || (s2_rm == RUP && !s2_sign[i]);
      oe         = er[E-1:0];
      om         = sum[M-1:0];
      fl         = '0;
      fl.inexact = grd | stk;
      if (s2_zero[i]) begin
        oe      = '0;
        om      = '0;
        fl      = '0;
        fl.zero = 1'b1;
      end else if (er >= EMAX) begin
        fl.ovf     = 1'b1;
        fl.inexact = 1'b1;
        oe = to_inf ? E'(exp_ones(E)) : E'(exp_ones(E) - 1);
        om = to_inf ? '0 : '1;
      end else if (ep <= EZERO) begin
`ifdef FP_NORM_SUBNORMAL_EN
        oe      = sum[M] ? E'(1) : '0;
        om      = sum[M-1:0];
        fl.uf   = fl.inexact;
        fl.zero = (sum == '0);
`else
        oe         = '0;
        om         = '0;
        fl.uf      = 1'b1;
        fl.zero    = 1'b1;
        fl.inexact = 1'b1;
`endif
      end
    end

    assign lane_unused = sum[M];
    assign oe_c[i] = oe;
    assign om_c[i] = om;
    assign fl_c[i] = fl;
  end
endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Randomized + directed bench for fp_normalize_round_pipe against a value-level model.
module tb_fp_normalize_round_pipe;
  import fp_pkg::*;

  localparam int M = 23, E = 8, LANES = 2, TAG_W = 8, MW = FP_MW;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [LANES-1:0]          in_sign, out_sign;
  logic [LANES-1:0][MW-1:0]  in_m;
  logic [LANES-1:0][E+1:0]   in_e;
  logic [1:0]                in_rm;
  logic [TAG_W-1:0]          in_tag, out_tag;
  logic [LANES-1:0][E-1:0]   out_e;
  logic [LANES-1:0][M-1:0]   out_m;
  logic [LANES-1:0][3:0]     out_flags;

  always #5 clk = ~clk;

  fp_normalize_round_pipe #(.M(M), .E(E), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_m(in_m), .in_e(in_e), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_e(out_e), .out_m(out_m), .out_flags(out_flags), .out_tag(out_tag)
  );

  typedef struct {
    logic [LANES-1:0]         sign;
    logic [LANES-1:0][E-1:0]  e;
    logic [LANES-1:0][M-1:0]  m;
    logic [LANES-1:0][3:0]    fl;
    logic [TAG_W-1:0]         tag;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit acc_f, got_f;
  logic [E-1:0] s_e;
  logic [M-1:0] s_m;
  logic [3:0]   s_fl;
  logic [TAG_W-1:0] s_tag;
  logic [TAG_W-1:0] tag_n = 8'h10;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value-level reference: locate the MSB, keep M+1 significant bits, round on the remainder.
  function automatic void ref_lane(input longint mm, input int e, input int rm, input bit s,
                                   output logic [E-1:0] oe, output logic [M-1:0] om,
                                   output logic [3:0] fl);
    int p, ep, epr, sh;
    longint kept, rem, half;
    bit up, inx, to_inf;
    oe = '0; om = '0; fl = 4'b0001;
    if (mm == 0) return;
    p = 0;
    for (int b = 0; b < MW; b++) if (mm[b]) p = b;
    ep = e + p - (2*M + 1);
    if (p > M) begin
      sh = p - M; kept = mm >> sh;
      rem = mm & ((64'sd1 <<< sh) - 1); half = 64'sd1 <<< (sh - 1);
    end else begin
      kept = mm <<< (M - p); rem = 0; half = 1;
    end
    inx = (rem != 0);
    case (rm)
      0:       up = (rem > half) || (rem == half && kept[0]);
      1:       up = 1'b0;
      2:       up = s && inx;
      default: up = !s && inx;
    endcase
    kept = kept + longint'(up);
    epr = ep;
    if (kept == (64'sd1 <<< (M + 1))) begin kept = 64'sd1 <<< M; epr = ep + 1; end
    if (epr >= (1 << E) - 1) begin
      to_inf = (rm == 0) || (rm == 2 && s) || (rm == 3 && !s);
      oe = to_inf ? E'((1 << E) - 1) : E'((1 << E) - 2);
      om = to_inf ? '0 : '1;
      fl = 4'b1010;
    end else if (ep <= 0) begin
      fl = 4'b0111;
    end else begin
      oe = epr[E-1:0]; om = kept[M-1:0]; fl = {2'b00, inx, 1'b0};
    end
  endfunction

  function automatic exp_t model();
    exp_t x;
    x.tag = in_tag;
    for (int l = 0; l < LANES; l++) begin
      x.sign[l] = in_sign[l];
      ref_lane(longint'(in_m[l]), int'($signed(in_e[l])), int'(in_rm), in_sign[l],
               x.e[l], x.m[l], x.fl[l]);
    end
    return x;
  endfunction

  task automatic cmp_out(input string nm, input exp_t x);
    for (int l = 0; l < LANES; l++)
      chk($sformatf("%s_lane%0d", nm, l),
          {out_sign[l], out_e[l], out_m[l], out_flags[l]},
          {x.sign[l], x.e[l], x.m[l], x.fl[l]});
    chk({nm, "_tag"}, out_tag, x.tag);
  endtask

  // Sample at negedge, score transfers/holds, then advance one clock.
  task automatic cycle();
    exp_t x;
    @(negedge clk);
    acc_f = in_valid && in_ready && !rst;
    got_f = out_valid && out_ready && !rst;
    s_e = out_e[0]; s_m = out_m[0]; s_fl = out_flags[0]; s_tag = out_tag;
    if (out_valid && !rst) begin
      if (q.size() == 0) chk("out_without_expect", out_valid, 1'b0);
      else begin
        x = q[0];
        cmp_out(got_f ? "xfer" : "hold", x);
        if (got_f) void'(q.pop_front());
      end
    end
    if (acc_f) q.push_back(model());
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] rand_m();
    longint r;
    r = {$urandom, $urandom};
    r = r & ((64'sd1 <<< MW) - 1);
    case ($urandom % 8)
      0:       r = 0;
      1:       r = r >> $urandom_range(0, MW);
      2:       r = (r >> 20) << 20;
      default: r = r >> $urandom_range(0, 30);
    endcase
    return r[MW-1:0];
  endfunction

  function automatic logic [E+1:0] rand_e();
    int v;
    case ($urandom % 5)
      0:       begin v = $urandom_range(0, 1023); v = v - 512; end
      1:       v = $urandom_range(240, 270);
      2:       begin v = $urandom_range(0, 60); v = v - 10; end
      default: v = $urandom_range(0, 300);
    endcase
    return v[E+1:0];
  endfunction

  task automatic rand_in();
    for (int l = 0; l < LANES; l++) begin
      in_m[l] = rand_m(); in_e[l] = rand_e(); in_sign[l] = $urandom_range(0, 1);
    end
    in_rm = 2'($urandom_range(0, 3));
    in_tag = 8'($urandom);
  endtask

  task automatic dir(input string nm, input longint m, input int e, input int rm, input bit s,
                     input logic [E-1:0] xe, input logic [M-1:0] xm, input logic [3:0] xf);
    int lat;
    logic [TAG_W-1:0] xt;
    rand_in();
    out_ready = 1'b1; in_valid = 1'b1;
    in_m[0] = m[MW-1:0]; in_e[0] = e[E+1:0]; in_sign[0] = s; in_rm = rm[1:0];
    in_tag = tag_n; xt = tag_n; tag_n = tag_n + 8'd1;
    cycle();
    chk({nm, "_acc"}, acc_f, 1'b1);
    in_valid = 1'b0;
    lat = 0;
    do begin cycle(); lat++; end while (!got_f && lat < 10);
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_e"}, s_e, xe);
    chk({nm, "_m"}, s_m, xm);
    chk({nm, "_flags"}, s_fl, xf);
    chk({nm, "_tag"}, s_tag, xt);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint tie;
    int nacc, nout, nstale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = '0; in_m = '0; in_e = '0; in_rm = 2'd0; in_tag = '0;
    repeat (3) cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", {out_sign, out_e, out_m, out_tag}, '0);
    chk("rst_out_flags", out_flags, '0);
    @(posedge clk); #1;

    tie = ((64'sd1 <<< 25) - 1) <<< 23;
    dir("unit",        64'sd1 <<< 47, 127, 0, 0, 8'd127, 23'h0, 4'b0000);
    dir("carry",       64'sd1 <<< 48, 127, 0, 0, 8'd128, 23'h0, 4'b0000);
    dir("lz18",        64'sd1 <<< 30, 127, 0, 0, 8'd110, 23'h0, 4'b0000);
    dir("rne_up",      tie,           100, 0, 0, 8'd101, 23'h0, 4'b0010);
    dir("rtz",         tie,           100, 1, 0, 8'd100, 23'h7FFFFF, 4'b0010);
    dir("tie_even",    (64'sd1 <<< 47) | (64'sd1 <<< 23), 127, 0, 0, 8'd127, 23'h0, 4'b0010);
    dir("rup_pos",     (64'sd1 <<< 47) | (64'sd1 <<< 23), 127, 3, 0, 8'd127, 23'h1, 4'b0010);
    dir("ovf_rne",     64'sd1 <<< 48, 254, 0, 0, 8'd255, 23'h0, 4'b1010);
    dir("ovf_rtz",     64'sd1 <<< 48, 254, 1, 0, 8'd254, 23'h7FFFFF, 4'b1010);
    dir("ovf_rdn_neg", 64'sd1 <<< 48, 254, 2, 1, 8'd255, 23'h0, 4'b1010);
    dir("ovf_rdn_pos", 64'sd1 <<< 48, 254, 2, 0, 8'd254, 23'h7FFFFF, 4'b1010);
    dir("ovf_rup_neg", 64'sd1 <<< 48, 254, 3, 1, 8'd254, 23'h7FFFFF, 4'b1010);
    dir("uf",          64'sd1,        10,  0, 0, 8'd0, 23'h0, 4'b0111);
    dir("zero",        64'sd0,        10,  0, 1, 8'd0, 23'h0, 4'b0001);

    // Full pipe under backpressure: only three inputs fit.
    out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
    rand_in();
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (acc_f) begin nacc++; rand_in(); end
    end
    chk("stall_accepted", nacc, 3);
    chk("stall_in_ready", in_ready, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1; nout = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (got_f) nout++;
    end
    chk("release_burst", nout, 3);

    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid && ($urandom % 4 != 0)) begin in_valid = 1'b1; rand_in(); end
      out_ready = ($urandom % 4 != 0);
      cycle();
      if (acc_f) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
    chk("drain_empty", q.size(), 0);

    // Reset with two transactions in flight.
    in_valid = 1'b1; rand_in(); cycle();
    rand_in(); cycle();
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    q.delete();
    chk("rst_flush_valid", out_valid, 1'b0);
    nstale = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (out_valid) nstale++;
    end
    chk("no_stale_after_rst", nstale, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
